// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: sequencer state type, default timing constants and saturating counter helper
package reset_sequencer_pkg;
   typedef enum logic [1:0] {HOLD, WAIT_LOCK, RUN} reset_seq_state_t;
   localparam int unsigned DEF_HOLD_CYCLES  = 128;
   localparam int unsigned DEF_LOCK_STABLE  = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT = 65536;
   localparam int unsigned DEF_SYNC_STAGES  = 2;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/reset_sequencer_sync_ff.sv
// reset_sequencer_sync_ff: SYNC_STAGES-flop bit synchronizer, async reset to 0
module reset_sequencer_sync_ff import reset_sequencer_pkg::*; #(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk_ext,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
   always_ff @(posedge clk_ext or posedge reset)
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges board reset, soft-reset request and clock lock into a clean ClockManager reset
module reset_sequencer import reset_sequencer_pkg::*; #(
   parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic       clk_ext,
   input  logic       reset,
   input  logic       cmd_reset_req,
   input  logic       clk_locked,
   output logic       mgr_reset,
   output logic       ready,
   output logic       lock_timeout,
   output logic [7:0] reseq_count
);
   localparam int unsigned HW = $clog2(HOLD_CYCLES);
   localparam int unsigned SW = $clog2(LOCK_STABLE);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT);
   localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE - 1);
   localparam logic [TW-1:0] TO_MAX     = TW'(LOCK_TIMEOUT - 1);

   logic req_s, lock_s;
   reset_seq_state_t state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [SW-1:0] stable_cnt_q, stable_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic req_s_dly_q, evt_q, evt_d;
   logic mgr_reset_q, mgr_reset_d, ready_q, ready_d, lock_timeout_q, lock_timeout_d;
   logic [7:0] reseq_count_q, reseq_count_d;
   logic timeout_hit, to_hold;

   reset_sequencer_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk_ext(clk_ext), .reset(reset), .d(cmd_reset_req), .q(req_s));
   reset_sequencer_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk_ext(clk_ext), .reset(reset), .d(clk_locked), .q(lock_s));

   // The request edge is registered so the FSM acts SYNC_STAGES+2 cycles after the input moves
   always_comb begin
      evt_d        = req_s & ~req_s_dly_q;
      timeout_hit  = (state_q == WAIT_LOCK) && (to_cnt_q == TO_MAX);
      to_hold      = (state_q == WAIT_LOCK) ? (evt_q | timeout_hit)
                   : (state_q == RUN)       ? (evt_q | ~lock_s) : 1'b0;
      state_d      = to_hold                ? HOLD
                   : (state_q == HOLD)      ? ((hold_cnt_q == '0 && !req_s) ? WAIT_LOCK : HOLD)
                   : (state_q == WAIT_LOCK) ? ((lock_s && stable_cnt_q == STABLE_MAX) ? RUN : WAIT_LOCK)
                   : state_q;
      hold_cnt_d   = to_hold ? HOLD_INIT
                   : (state_q == HOLD && hold_cnt_q != '0) ? hold_cnt_q - HW'(1) : hold_cnt_q;
      stable_cnt_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK && lock_s) ? stable_cnt_q + SW'(1) : '0;
      to_cnt_d     = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? to_cnt_q + TW'(1) : '0;
      mgr_reset_d    = (state_d == HOLD);
      ready_d        = (state_d == RUN);
      lock_timeout_d = lock_timeout_q | timeout_hit;
      reseq_count_d  = to_hold ? sat_inc(reseq_count_q) : reseq_count_q;
   end

   always_ff @(posedge clk_ext or posedge reset) begin
      if (reset) begin
         state_q        <= HOLD;
         hold_cnt_q     <= HOLD_INIT;
         stable_cnt_q   <= '0;
         to_cnt_q       <= '0;
         req_s_dly_q    <= 1'b0;
         evt_q          <= 1'b0;
         mgr_reset_q    <= 1'b1;
         ready_q        <= 1'b0;
         lock_timeout_q <= 1'b0;
         reseq_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         hold_cnt_q     <= hold_cnt_d;
         stable_cnt_q   <= stable_cnt_d;
         to_cnt_q       <= to_cnt_d;
         req_s_dly_q    <= req_s;
         evt_q          <= evt_d;
         mgr_reset_q    <= mgr_reset_d;
         ready_q        <= ready_d;
         lock_timeout_q <= lock_timeout_d;
         reseq_count_q  <= reseq_count_d;
      end
   end

   assign mgr_reset    = mgr_reset_q;
   assign ready        = ready_q;
   assign lock_timeout = lock_timeout_q;
   assign reseq_count  = reseq_count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a cycle-level reference model
module tb_reset_sequencer;
   localparam int HOLD    = 128;
   localparam int STABLE  = 16;
   localparam int TIMEOUT = 1000;

   logic clk_ext = 1'b0;
   logic reset, cmd_reset_req, clk_locked;
   logic mgr_reset, ready, lock_timeout;
   logic [7:0] reseq_count;
   int checks = 0;
   int errors = 0;

   reset_sequencer #(.HOLD_CYCLES(HOLD), .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
      .clk_ext(clk_ext), .reset(reset), .cmd_reset_req(cmd_reset_req), .clk_locked(clk_locked),
      .mgr_reset(mgr_reset), .ready(ready), .lock_timeout(lock_timeout), .reseq_count(reseq_count));

   always #5 clk_ext = ~clk_ext;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 = hold, 1 = waiting for lock, 2 = running.
   // rin/lin[k] hold the raw input seen k clock edges ago; two synchronizer flops
   // make the synced level two edges old and the registered request edge three.
   int m_mode, m_age, m_waited, m_run1, m_cnt;
   bit m_to;
   bit rin [1:4];
   bit lin [1:4];
   always @(posedge clk_ext or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_age = 0; m_waited = 0; m_run1 = 0; m_cnt = 0; m_to = 0;
         for (int k = 1; k <= 4; k++) begin rin[k] = 0; lin[k] = 0; end
      end else begin
         bit rs, ls, ev, go_hold;
         rs = rin[2]; ls = lin[2]; ev = rin[3] && !rin[4]; go_hold = 0;
         if (m_mode == 0) begin
            m_age++;
            if (m_age >= HOLD && !rs) begin m_mode = 1; m_waited = 0; m_run1 = 0; end
         end else if (m_mode == 1) begin
            m_waited++;
            if (m_waited >= TIMEOUT) m_to = 1;
            if (ev || m_waited >= TIMEOUT) go_hold = 1;
            else begin
               m_run1 = ls ? m_run1 + 1 : 0;
               if (m_run1 >= STABLE) m_mode = 2;
            end
         end else go_hold = ev || !ls;
         if (go_hold) begin
            m_mode = 0; m_age = 0;
            if (m_cnt < 255) m_cnt++;
         end
         for (int k = 4; k > 1; k--) begin rin[k] = rin[k-1]; lin[k] = lin[k-1]; end
         rin[1] = cmd_reset_req; lin[1] = clk_locked;
      end
   end

   always @(negedge clk_ext) begin
      check("model_mgr_reset", mgr_reset, int'(m_mode == 0));
      check("model_ready", ready, int'(m_mode == 2));
      check("model_lock_timeout", lock_timeout, m_to);
      check("model_reseq_count", reseq_count, m_cnt);
   end

   function automatic bit out_sel(input int which);
      return (which == 0) ? mgr_reset : (which == 1) ? ready : lock_timeout;
   endfunction

   task automatic wait_val(input int which, input bit val, input int bound, input string name);
      int n = 0;
      while (out_sel(which) !== val && n < bound) begin @(negedge clk_ext); n++; end
      check(name, int'(n < bound), 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base, rise, fall;
      bit left;
      reset = 1'b0; cmd_reset_req = 1'b0; clk_locked = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk_ext);
      check("rst_mgr_reset", mgr_reset, 1);
      check("rst_ready", ready, 0);
      check("rst_lock_timeout", lock_timeout, 0);
      check("rst_reseq_count", reseq_count, 0);
      reset = 1'b0;
      // power-up: lock arrives 10 cycles after release
      n = 0;
      for (int i = 0; i < 300 && mgr_reset; i++) begin
         n++;
         if (i == 10) clk_locked = 1'b1;
         @(negedge clk_ext);
      end
      check("pwr_hold_len", n, 128);
      n = 0;
      while (!ready && n < 100) begin @(negedge clk_ext); n++; end
      check("pwr_lock_to_ready", n, 16);
      check("pwr_reseq_count", reseq_count, 0);
      // soft reset: 5-cycle request pulse in RUN
      repeat (5) @(negedge clk_ext);
      cmd_reset_req = 1'b1; n = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_ext);
         if (mgr_reset && n == 0) n = i;
      end
      cmd_reset_req = 1'b0;
      check("soft_latency", n, 4);
      n = 1;
      while (mgr_reset && n < 1000) begin n++; @(negedge clk_ext); end
      check("soft_hold_len", n, 128);
      wait_val(1, 1'b1, 100, "soft_back_to_run");
      check("soft_reseq_count", reseq_count, 1);
      // long request: 500 cycles high
      base = reseq_count; cmd_reset_req = 1'b1; rise = 0; fall = 0;
      for (int i = 1; i <= 700; i++) begin
         @(negedge clk_ext);
         if (i == 500) cmd_reset_req = 1'b0;
         if (mgr_reset && rise == 0) rise = i;
         if (!mgr_reset && rise != 0 && fall == 0) fall = i;
      end
      check("long_rise", rise, 4);
      check("long_release", fall, 503);
      check("long_reseq_once", reseq_count, base + 1);
      check("long_back_to_run", ready, 1);
      // lock loss in RUN, then lock held low until timeouts
      check("timeout_flag_before", lock_timeout, 0);
      clk_locked = 1'b0; n = 0;
      while (!(mgr_reset && !ready) && n < 10) begin @(negedge clk_ext); n++; end
      check("loss_within_4", int'(n >= 1 && n <= 4), 1);
      base = reseq_count;
      wait_val(0, 1'b0, 300, "to_first_wait");
      n = 0;
      while (!mgr_reset && n < 2000) begin n++; @(negedge clk_ext); end
      check("to_wait_len", n, 1000);
      check("to_flag_set", lock_timeout, 1);
      check("to_reseq_1", reseq_count, base + 1);
      wait_val(0, 1'b0, 300, "to_second_wait");
      wait_val(0, 1'b1, 1200, "to_second_hold");
      check("to_reseq_2", reseq_count, base + 2);
      // one-cycle lock glitch at stable count 10 in WAIT_LOCK
      clk_locked = 1'b1;
      wait_val(0, 1'b0, 300, "glitch_wait_entry");
      n = 0; left = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin
         if (i == 9) clk_locked = 1'b0;
         if (i == 10) clk_locked = 1'b1;
         @(negedge clk_ext);
         if (mgr_reset) left = 1;
         if (ready) n = i;
      end
      check("glitch_ready_delay", n, 27);
      check("glitch_stays_waiting", left, 0);
      // random traffic, compared cycle by cycle against the model
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_ext);
         if (cmd_reset_req) begin if ($urandom_range(0, 99) < 10) cmd_reset_req = 1'b0; end
         else if ($urandom_range(0, 999) < 8) cmd_reset_req = 1'b1;
         if (clk_locked) begin if ($urandom_range(0, 999) < 4) clk_locked = 1'b0; end
         else if ($urandom_range(0, 99) < 20) clk_locked = 1'b1;
      end
      cmd_reset_req = 1'b0; clk_locked = 1'b1;
      // async reset mid-HOLD
      repeat (10) @(negedge clk_ext);
      cmd_reset_req = 1'b1;
      repeat (2) @(negedge clk_ext);
      cmd_reset_req = 1'b0;
      wait_val(0, 1'b1, 20, "mid_hold_enter");
      repeat (20) @(negedge clk_ext);
      check("sticky_before_reset", lock_timeout, 1);
      #2 reset = 1'b1;
      #1;
      check("async_mgr_reset", mgr_reset, 1);
      check("async_ready", ready, 0);
      check("async_lock_timeout", lock_timeout, 0);
      check("async_reseq_count", reseq_count, 0);
      @(negedge clk_ext);
      reset = 1'b0; clk_locked = 1'b0;
      // saturation: 300 re-sequences via requests in WAIT_LOCK
      for (int k = 0; k < 300; k++) begin
         wait_val(0, 1'b0, 300, "sat_hold_exit");
         cmd_reset_req = 1'b1;
         repeat (2) @(negedge clk_ext);
         cmd_reset_req = 1'b0;
         wait_val(0, 1'b1, 10, "sat_rehold");
      end
      check("sat_reseq_count", reseq_count, 255);
      repeat (5) @(negedge clk_ext);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
